// File: rtl/calculator_pkg.sv
// Shared calculator datapath definitions: memory geometry, the operand
// width, the preload FSM state encoding and the operand pair packing helper.
package calculator_pkg;

  localparam int ADDR_W        = 10;
  localparam int DATA_W        = 32;
  localparam int MEM_WORD_SIZE = 64;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2
  } loader_state_e;

  // Packs two operands into one memory word. The first operand of the pair
  // goes to the low half when lo_first is set, otherwise to the high half.
  function automatic logic [MEM_WORD_SIZE-1:0] pack_pair(
    input logic              lo_first,
    input logic [DATA_W-1:0] first,
    input logic [DATA_W-1:0] second
  );
    return lo_first ? {second, first} : {first, second};
  endfunction

endpackage

// File: rtl/calc_mem_loader.sv
// Operand preload stage. It takes 32-bit operands over a valid/ready
// handshake, packs each pair into a 64-bit word, writes the word to the SRAM
// across an inclusive and wrapping address range, and pulses done_o.
// Optional feature: define CALC_LOADER_CHECKSUM_EN to add checksum_o. It is
// the XOR of every word written since the last accepted start.
module calc_mem_loader
  import calculator_pkg::*;
#(
  parameter bit LOW_FIRST = 1'b1
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     start_i,
  input  logic [ADDR_W-1:0]        start_addr_i,
  input  logic [ADDR_W-1:0]        end_addr_i,
  input  logic                     in_valid_i,
  input  logic [DATA_W-1:0]        in_data_i,
  output logic                     in_ready_o,
  output logic                     write_o,
  output logic [ADDR_W-1:0]        w_addr_o,
  output logic [MEM_WORD_SIZE-1:0] w_data_o,
  output logic                     busy_o,
  output logic                     done_o
`ifdef CALC_LOADER_CHECKSUM_EN
  ,
  output logic [MEM_WORD_SIZE-1:0] checksum_o
`endif
);

  loader_state_e            state;
  logic [ADDR_W-1:0]        addr_cnt;
  logic [ADDR_W-1:0]        end_addr;
  logic                     half;
  logic [DATA_W-1:0]        hold;
  logic                     beat;
  logic [MEM_WORD_SIZE-1:0] word;

  // The handshake outputs are decoded from the state register only, so
  // in_valid_i has no combinational path to in_ready_o.
  assign in_ready_o = (state == LOAD);
  assign busy_o     = (state != IDLE);
  assign done_o     = (state == DONE);
  assign beat       = in_valid_i && in_ready_o;

  // Combine the held first beat with the beat being accepted now.
  always_comb begin
    word = pack_pair(LOW_FIRST, hold, in_data_i);
  end

  // Load FSM with the address counter, the pair holding register and the
  // registered SRAM write port.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state    <= IDLE;
      addr_cnt <= '0;
      end_addr <= '0;
      half     <= 1'b0;
      hold     <= '0;
      write_o  <= 1'b0;
      w_addr_o <= '0;
      w_data_o <= '0;
    end else begin
      write_o <= 1'b0;
      case (state)
        IDLE: begin
          if (start_i) begin
            addr_cnt <= start_addr_i;
            end_addr <= end_addr_i;
            half     <= 1'b0;
            state    <= LOAD;
          end
        end
        LOAD: begin
          if (beat) begin
            if (!half) begin
              hold <= in_data_i;
              half <= 1'b1;
            end else begin
              write_o  <= 1'b1;
              w_addr_o <= addr_cnt;
              w_data_o <= word;
              half     <= 1'b0;
              // The counter wraps modulo 2^ADDR_W, so a range whose end is
              // below its start runs through the top of memory.
              if (addr_cnt == end_addr) state <= DONE;
              else                      addr_cnt <= addr_cnt + 1'b1;
            end
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

`ifdef CALC_LOADER_CHECKSUM_EN
  // Running XOR of the written words. It is cleared when a start is accepted
  // and is updated on the same edge that registers write_o.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      checksum_o <= '0;
    end else if (state == IDLE && start_i) begin
      checksum_o <= '0;
    end else if (beat && half) begin
      checksum_o <= checksum_o ^ word;
    end
  end
`endif

endmodule

// File: doc/calc_mem_loader.md
# calc_mem_loader

Upstream preload stage for the calculator datapath: accepts a stream of 32-bit operands over a valid/ready handshake and packs each pair into one 64-bit memory word. It drives the SRAM write port (write enable, address, data) across a programmed address range, so operand memory is populated before the controller's read/compute/write-back pass. It signals completion with a one-cycle done pulse.

## Interface
- LOW_FIRST, default 1: 1 = first accepted beat of a pair goes to bits [31:0], second to [63:32]; 0 = reversed.
- clk_i  in  1  single clock; all state on rising edge
- rst_i  in  1  asynchronous, active-high reset
- start_i  in  1  begin a load; sampled only in IDLE
- start_addr_i  in  ADDR_W  first word address, latched on start
- end_addr_i  in  ADDR_W  last word address (inclusive), latched on start
- in_valid_i  in  1  input beat valid
- in_data_i  in  DATA_W  input operand (32 b)
- in_ready_o  out  1  loader can accept a beat
- write_o  out  1  SRAM write strobe, active high; one cycle per 64-bit word
- w_addr_o  out  ADDR_W  SRAM write address
- w_data_o  out  MEM_WORD_SIZE  packed 64-bit write data
- busy_o  out  1  high in LOAD and DONE
- done_o  out  1  one-cycle completion pulse
- checksum_o  out  MEM_WORD_SIZE  present only with CALC_LOADER_CHECKSUM_EN

## Operation
- FSM states: IDLE, LOAD, DONE.
- IDLE: in_ready_o=0. On start_i=1, latch start/end addresses, set address counter = start_addr_i, clear half flag, go to LOAD.
- LOAD: in_ready_o=1 unconditionally (SRAM write never back-pressures). A beat transfers when in_valid_i && in_ready_o.
  - Half flag 0: store beat in holding register, set flag.
  - Half flag 1: form 64-bit word from holding register + current beat per LOW_FIRST, register write_o=1, w_addr_o=counter, w_data_o=word; clear flag. If counter == end addr, go to DONE; else counter+1.
- DONE: in_ready_o=0, done_o=1 for exactly this cycle, then IDLE.
- Address counter is ADDR_W bits and wraps modulo 2^ADDR_W; end < start loads through the wrap (e.g. start=0x3FE, end=0x001 on ADDR_W=10 writes 4 words).
- start == end: exactly one word written.
- start_i while busy_o=1: ignored.
- in_valid_i in IDLE/DONE: not accepted (ready low); no data captured.
- Reset (any time, including mid-pair): state IDLE, half flag cleared, held beat discarded; no write issued.

## Timing
- Reset values: in_ready_o=0, write_o=0, w_addr_o=0, w_data_o=0, busy_o=0, done_o=0, checksum_o=0.
- start_i sampled at edge E → LOAD and in_ready_o=1 from cycle E+1.
- Second beat of pair accepted at edge N → write_o, w_addr_o, w_data_o valid during cycle N+1; write_o low otherwise. w_addr_o/w_data_o hold last value when write_o=0.
- Final pair: DONE entered at edge N; done_o and the final write_o are high in the same cycle N+1; IDLE from N+2.
- Throughput: one beat/cycle, one SRAM word per two beats. in_ready_o, busy_o, done_o decoded from registered state only (no combinational path from in_valid_i).

## Configuration
- CALC_LOADER_CHECKSUM_EN defined: checksum_o = XOR of every w_data_o written since last start; cleared on accepted start_i; updated alongside write_o; final value valid in done_o cycle and held until next start.
- Not defined: checksum_o port and accumulator absent; all other behaviour identical.

## Structure
- calculator_pkg: ADDR_W, DATA_W, MEM_WORD_SIZE (reused), plus loader state enum typedef (IDLE/LOAD/DONE).
- Single module, no sub-modules; packing/holding register inline.

## Test plan
- Basic: start=0x000, end=0x001, beats 0x1,0x2,0x3,0x4 back-to-back → writes {0x2,0x1}@0x000, {0x4,0x3}@0x001; done_o with second write; 6 cycles start→IDLE.
- Gapped valid: same load with in_valid_i low 3 cycles between beats → identical writes, write_o only on pair completion.
- Wrap: ADDR_W=10, start=0x3FF, end=0x000 → writes at 0x3FF then 0x000, then done.
- start=end=0x010, beats 0xAAAA_AAAA,0x5555_5555 → one write 0x5555_5555_AAAA_AAAA@0x010; start_i re-pulsed mid-load ignored.
- Reset after one beat of a pair → no write, outputs at reset values; new load behaves as fresh.
- With CALC_LOADER_CHECKSUM_EN: words 0xF0 and 0x0F (64-bit) → checksum_o=0xFF at done_o; cleared to 0 on next start.
